// File: rtl/cp0_exc_ctrl.sv
// CP0 register file with exception entry/return sequencing, a Count
// prescaler, the Cause.TI timer flag and a masked interrupt request.
module cp0_exc_ctrl #(
    parameter int unsigned HW_INT_NUM   = 6,
    parameter int unsigned TIMER_IP_IDX = 5,
    parameter int unsigned COUNT_DIV    = 2,
    parameter logic [31:0] STATUS_RST   = 32'h0040_0000
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  mtc0_en_i,
    input  logic [4:0]            mtc0_addr_i,
    input  logic [31:0]           mtc0_data_i,
    input  logic [4:0]            mfc0_addr_i,
    output logic [31:0]           mfc0_data_o,
    input  logic [HW_INT_NUM-1:0] hw_int_i,
    input  logic                  exc_valid_i,
    input  logic [4:0]            exc_code_i,
    input  logic [31:0]           exc_pc_i,
    input  logic                  exc_bd_i,
    input  logic                  exc_bva_en_i,
    input  logic [31:0]           exc_bva_i,
    input  logic                  eret_i,
    output logic                  int_req_o,
    output logic                  timer_int_o,
    output logic                  flush_o,
    output logic [31:0]           flush_pc_o
);

    localparam logic [2:0] TimerIdx  = 3'(TIMER_IP_IDX);
    localparam logic       PhaseLast = 1'(COUNT_DIV - 1);

    logic [31:0] badvaddr_q, badvaddr_d;
    logic [31:0] count_q, count_d;
    logic [31:0] compare_q, compare_d;
    logic [31:0] status_q, status_d;
    logic [31:0] epc_q, epc_d;
    logic        bd_q, bd_d;
    logic        ti_q, ti_d;
    logic [7:0]  ip_q, ip_d;
    logic [4:0]  exc_code_q, exc_code_d;
    logic        phase_q, phase_d;
    logic        flush_q, flush_d;
    logic [31:0] flush_pc_q, flush_pc_d;

    logic        eret_live;
    logic        mtc0_live;
    logic        wr_count, wr_compare, wr_status, wr_cause, wr_epc;
    logic [5:0]  hw_ip;
    logic        exl;

    assign exl       = status_q[1];
    // An effective eret drops any same-cycle mtc0; an exception only masks the
    // fields it updates itself.
    assign eret_live = eret_i & ~exc_valid_i;
    assign mtc0_live = mtc0_en_i & ~eret_live;
    assign wr_count   = mtc0_live && (mtc0_addr_i == 5'd9);
    assign wr_compare = mtc0_live && (mtc0_addr_i == 5'd11);
    assign wr_status  = mtc0_live && (mtc0_addr_i == 5'd12);
    assign wr_cause   = mtc0_live && (mtc0_addr_i == 5'd13);
    assign wr_epc     = mtc0_live && !exc_valid_i && (mtc0_addr_i == 5'd14);

    // Hardware IP sources: external levels with the timer flag folded in.
    always_comb begin
        hw_ip = '0;
        for (int i = 0; i < HW_INT_NUM; i++) begin
            hw_ip[i] = hw_int_i[i];
        end
        hw_ip[TimerIdx] = hw_ip[TimerIdx] | ti_q;
    end

    // Next-state for all CP0 registers, prescaler and flush outputs.
    always_comb begin
        badvaddr_d = badvaddr_q;
        count_d    = count_q;
        compare_d  = compare_q;
        status_d   = status_q;
        epc_d      = epc_q;
        bd_d       = bd_q;
        ti_d       = ti_q;
        exc_code_d = exc_code_q;
        phase_d    = phase_q;
        ip_d       = {hw_ip, ip_q[1:0]};
        flush_d    = exc_valid_i | eret_live;
        flush_pc_d = '0;

        if (wr_count) begin
            count_d = mtc0_data_i;
            phase_d = 1'b0;
        end else if (phase_q == PhaseLast) begin
            count_d = count_q + 32'd1;
            phase_d = 1'b0;
        end else begin
            phase_d = 1'b1;
        end

        if (wr_compare) begin
            compare_d = mtc0_data_i;
            ti_d      = 1'b0;
        end else if (count_q == compare_q) begin
            ti_d = 1'b1;
        end

        if (wr_status) begin
            status_d[15:8] = mtc0_data_i[15:8];
            status_d[1:0]  = mtc0_data_i[1:0];
        end
        if (wr_cause) begin
            ip_d[1:0] = mtc0_data_i[9:8];
        end
        if (wr_epc) begin
            epc_d = mtc0_data_i;
        end

        if (exc_valid_i) begin
            if (!exl) begin
                epc_d = exc_bd_i ? exc_pc_i - 32'd4 : exc_pc_i;
                bd_d  = exc_bd_i;
            end
            status_d[1] = 1'b1;
            exc_code_d  = exc_code_i;
            if (exc_bva_en_i) begin
                badvaddr_d = exc_bva_i;
            end
            flush_pc_d = status_q[22] ? 32'hBFC0_0380 : 32'h8000_0180;
        end else if (eret_i) begin
            status_d[1] = 1'b0;
            flush_pc_d  = epc_q;
        end
    end

    // State registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            badvaddr_q <= '0;
            count_q    <= '0;
            compare_q  <= '0;
            status_q   <= STATUS_RST;
            epc_q      <= '0;
            bd_q       <= 1'b0;
            ti_q       <= 1'b0;
            ip_q       <= '0;
            exc_code_q <= '0;
            phase_q    <= 1'b0;
            flush_q    <= 1'b0;
            flush_pc_q <= '0;
        end else begin
            badvaddr_q <= badvaddr_d;
            count_q    <= count_d;
            compare_q  <= compare_d;
            status_q   <= status_d;
            epc_q      <= epc_d;
            bd_q       <= bd_d;
            ti_q       <= ti_d;
            ip_q       <= ip_d;
            exc_code_q <= exc_code_d;
            phase_q    <= phase_d;
            flush_q    <= flush_d;
            flush_pc_q <= flush_pc_d;
        end
    end

    // Read mux and register-derived outputs.
    always_comb begin
        unique case (mfc0_addr_i)
            5'd8:    mfc0_data_o = badvaddr_q;
            5'd9:    mfc0_data_o = count_q;
            5'd11:   mfc0_data_o = compare_q;
            5'd12:   mfc0_data_o = status_q;
            5'd13:   mfc0_data_o = {bd_q, ti_q, 14'b0, ip_q, 1'b0, exc_code_q, 2'b0};
            5'd14:   mfc0_data_o = epc_q;
            default: mfc0_data_o = '0;
        endcase
        int_req_o   = status_q[0] & ~exl & |(ip_q & status_q[15:8]);
        timer_int_o = ti_q;
        flush_o     = flush_q;
        flush_pc_o  = flush_pc_q;
    end

endmodule
